// File: rtl/machine_press_solver_pkg.sv
// Shared types and helpers for the minimum-press light-panel solver.
package machine_solver_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    RESULT = 2'd2
  } state_t;

  // Width needed to hold a count in the range 0..n.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 32'd1);
  endfunction

  // True when candidate a must replace candidate b: a hits and either b
  // misses, a needs fewer presses, or both tie and a has the lower subset.
  function automatic logic lane_beats(
    input logic        hit_a,
    input int unsigned pc_a,
    input int unsigned s_a,
    input logic        hit_b,
    input int unsigned pc_b,
    input int unsigned s_b
  );
    logic beats;
    if (!hit_a) begin
      beats = 1'b0;
    end else if (!hit_b) begin
      beats = 1'b1;
    end else if (pc_a != pc_b) begin
      beats = (pc_a < pc_b);
    end else begin
      beats = (s_a < s_b);
    end
    return beats;
  endfunction

endpackage

// File: rtl/machine_press_solver_chk.sv
// Input-legality checks for accepted machine descriptors.
module machine_press_solver_chk #(
  parameter int unsigned MAX_NUM_LIGHTS  = 10,
  parameter int unsigned MAX_NUM_BUTTONS = 13
) (
  input logic                                 clk_i,
  input logic                                 rst_i,
  input logic                                 in_valid_i,
  input logic                                 in_ready_i,
  input logic [$clog2(MAX_NUM_LIGHTS+1)-1:0]  num_lights_i,
  input logic [$clog2(MAX_NUM_BUTTONS+1)-1:0] num_buttons_i
);

  a_legal_machine: assert property (@(posedge clk_i) disable iff (rst_i)
    (in_valid_i && in_ready_i) |->
      ((32'(num_lights_i) != 32'd0) &&
       (32'(num_lights_i) <= MAX_NUM_LIGHTS) &&
       (32'(num_buttons_i) <= MAX_NUM_BUTTONS)));

endmodule

// File: rtl/machine_press_solver_lane.sv
// One search lane: XOR of the selected buttons compared against the target
// on the active lights, plus the number of buttons pressed.
module subset_lane_eval #(
  parameter int unsigned NL   = 10,
  parameter int unsigned NB   = 13,
  parameter int unsigned PC_W = 4
) (
  input  logic [NB-1:0]         subset_i,
  input  logic [NB-1:0][NL-1:0] buttons_i,
  input  logic [NL-1:0]         target_i,
  input  logic [NL-1:0]         light_mask_i,
  output logic                  hit_o,
  output logic [PC_W-1:0]       popcount_o
);

  logic [NL-1:0]   acc_s;
  logic [PC_W-1:0] pc_s;

  // Accumulate toggles and press count of the selected buttons.
  always_comb begin
    acc_s = {NL{1'b0}};
    pc_s  = {PC_W{1'b0}};
    for (int b = 0; b < int'(NB); b++) begin
      if (subset_i[b]) begin
        acc_s = acc_s ^ buttons_i[b];
        pc_s  = pc_s + PC_W'(1);
      end else begin
        acc_s = acc_s;
        pc_s  = pc_s;
      end
    end
    hit_o      = (((acc_s ^ target_i) & light_mask_i) == {NL{1'b0}});
    popcount_o = pc_s;
  end

endmodule

// File: rtl/machine_press_solver.sv
// Exhaustive GF(2) minimum-press solver, LANES subsets per cycle.
// Optional running press total enabled by defining CFG_SOLVER_TOTAL_EN.
module machine_press_solver
  import machine_solver_pkg::*;
#(
  parameter int unsigned MAX_NUM_LIGHTS  = 10,
  parameter int unsigned MAX_NUM_BUTTONS = 13,
  parameter int unsigned LANES           = 4,
  parameter int unsigned TOTAL_W         = 32
) (
  input  logic                                            clk_i,
  input  logic                                            rst_i,
  input  logic                                            in_valid_i,
  output logic                                            in_ready_o,
  input  logic [$clog2(MAX_NUM_LIGHTS+1)-1:0]             in_num_lights_i,
  input  logic [$clog2(MAX_NUM_BUTTONS+1)-1:0]            in_num_buttons_i,
  input  logic [MAX_NUM_LIGHTS-1:0]                       in_target_i,
  input  logic [MAX_NUM_BUTTONS-1:0][MAX_NUM_LIGHTS-1:0]  in_buttons_i,
  output logic                                            out_valid_o,
  input  logic                                            out_ready_i,
  output logic                                            out_found_o,
  output logic [$clog2(MAX_NUM_BUTTONS+1)-1:0]            out_presses_o,
  output logic [MAX_NUM_BUTTONS-1:0]                      out_mask_o
`ifdef CFG_SOLVER_TOTAL_EN
  ,
  output logic [TOTAL_W-1:0]                              total_presses_o
`endif
);

  localparam int unsigned NB     = MAX_NUM_BUTTONS;
  localparam int unsigned NL     = MAX_NUM_LIGHTS;
  localparam int unsigned CNT_W  = cnt_w(MAX_NUM_BUTTONS);
  localparam int unsigned BASE_W = MAX_NUM_BUTTONS + 1;
  localparam int unsigned NODES  = 2 * LANES - 1;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      nb_q, nb_d;
  logic [NL-1:0]         light_mask_q, light_mask_d;
  logic [NL-1:0]         target_q, target_d;
  logic [NB-1:0][NL-1:0] buttons_q, buttons_d;
  logic [BASE_W-1:0]     base_q, base_d;
  logic [CNT_W-1:0]      best_q, best_d;
  logic [NB-1:0]         best_mask_q, best_mask_d;
  logic                  found_q, found_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_found_q, out_found_d;
  logic [CNT_W-1:0]      out_presses_q, out_presses_d;
  logic [NB-1:0]         out_mask_q, out_mask_d;

  logic [BASE_W-1:0]     limit_s;
  logic [BASE_W-1:0]     lane_s_s   [LANES];
  logic                  lane_raw_s [LANES];
  logic                  lane_hit_s [LANES];
  logic [CNT_W-1:0]      lane_pc_s  [LANES];
  logic                  win_hit_s;
  logic [CNT_W-1:0]      win_pc_s;
  logic [NB-1:0]         win_s_s;

  assign limit_s = BASE_W'(1) << nb_q;

  for (genvar k = 0; k < int'(LANES); k++) begin : g_lane
    assign lane_s_s[k] = base_q + BASE_W'(k);

    subset_lane_eval #(.NL(NL), .NB(NB), .PC_W(CNT_W)) u_lane (
      .subset_i     (lane_s_s[k][NB-1:0]),
      .buttons_i    (buttons_q),
      .target_i     (target_q),
      .light_mask_i (light_mask_q),
      .hit_o        (lane_raw_s[k]),
      .popcount_o   (lane_pc_s[k])
    );

    // Subsets past the end of the search space never count as hits.
    assign lane_hit_s[k] = lane_raw_s[k] && (lane_s_s[k] < limit_s);
  end

  // Min-reduction tree over lanes; left children always carry lower subsets.
  always_comb begin
    logic             node_hit [NODES];
    logic [CNT_W-1:0] node_pc  [NODES];
    logic [NB-1:0]    node_s   [NODES];
    for (int k = 0; k < int'(LANES); k++) begin
      node_hit[int'(LANES) - 1 + k] = lane_hit_s[k];
      node_pc[int'(LANES) - 1 + k]  = lane_pc_s[k];
      node_s[int'(LANES) - 1 + k]   = lane_s_s[k][NB-1:0];
    end
    for (int i = int'(LANES) - 2; i >= 0; i--) begin
      if (lane_beats(node_hit[2*i+2], 32'(node_pc[2*i+2]), 32'(node_s[2*i+2]),
                     node_hit[2*i+1], 32'(node_pc[2*i+1]), 32'(node_s[2*i+1]))) begin
        node_hit[i] = node_hit[2*i+2];
        node_pc[i]  = node_pc[2*i+2];
        node_s[i]   = node_s[2*i+2];
      end else begin
        node_hit[i] = node_hit[2*i+1];
        node_pc[i]  = node_pc[2*i+1];
        node_s[i]   = node_s[2*i+1];
      end
    end
    win_hit_s = node_hit[0];
    win_pc_s  = node_pc[0];
    win_s_s   = node_s[0];
  end

  // FSM next-state and datapath updates.
  always_comb begin
    state_d       = state_q;
    nb_d          = nb_q;
    light_mask_d  = light_mask_q;
    target_d      = target_q;
    buttons_d     = buttons_q;
    base_d        = base_q;
    best_d        = best_q;
    best_mask_d   = best_mask_q;
    found_d       = found_q;
    out_found_d   = out_found_q;
    out_presses_d = out_presses_q;
    out_mask_d    = out_mask_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i && in_ready_q) begin
          nb_d      = in_num_buttons_i;
          target_d  = in_target_i;
          buttons_d = in_buttons_i;
          for (int i = 0; i < int'(NL); i++) begin
            light_mask_d[i] = (32'(i) < 32'(in_num_lights_i));
          end
          base_d      = {BASE_W{1'b0}};
          best_d      = {CNT_W{1'b1}};
          best_mask_d = {NB{1'b0}};
          found_d     = 1'b0;
          state_d     = SEARCH;
        end else begin
          state_d = IDLE;
        end
      end
      SEARCH: begin
        if (win_hit_s && (win_pc_s < best_q)) begin
          best_d      = win_pc_s;
          best_mask_d = win_s_s;
          found_d     = 1'b1;
        end else begin
          best_d = best_q;
        end
        base_d = base_q + BASE_W'(LANES);
        if ((base_q + BASE_W'(LANES)) >= limit_s) begin
          out_found_d   = found_d;
          out_presses_d = best_d;
          out_mask_d    = best_mask_d;
          state_d       = RESULT;
        end else begin
          state_d = SEARCH;
        end
      end
      RESULT: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = RESULT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == RESULT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      nb_q          <= {CNT_W{1'b0}};
      light_mask_q  <= {NL{1'b0}};
      target_q      <= {NL{1'b0}};
      buttons_q     <= '0;
      base_q        <= {BASE_W{1'b0}};
      best_q        <= {CNT_W{1'b1}};
      best_mask_q   <= {NB{1'b0}};
      found_q       <= 1'b0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_found_q   <= 1'b0;
      out_presses_q <= {CNT_W{1'b1}};
      out_mask_q    <= {NB{1'b0}};
    end else begin
      state_q       <= state_d;
      nb_q          <= nb_d;
      light_mask_q  <= light_mask_d;
      target_q      <= target_d;
      buttons_q     <= buttons_d;
      base_q        <= base_d;
      best_q        <= best_d;
      best_mask_q   <= best_mask_d;
      found_q       <= found_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_found_q   <= out_found_d;
      out_presses_q <= out_presses_d;
      out_mask_q    <= out_mask_d;
    end
  end

  assign in_ready_o    = in_ready_q;
  assign out_valid_o   = out_valid_q;
  assign out_found_o   = out_found_q;
  assign out_presses_o = out_presses_q;
  assign out_mask_o    = out_mask_q;

`ifdef CFG_SOLVER_TOTAL_EN
  logic [TOTAL_W-1:0] total_q, total_d;

  // Add the press count of every solved machine as it is handed off.
  always_comb begin
    if (out_valid_q && out_ready_i && out_found_q) begin
      total_d = total_q + TOTAL_W'(out_presses_q);
    end else begin
      total_d = total_q;
    end
  end

  // Running total register, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      total_q <= {TOTAL_W{1'b0}};
    end else begin
      total_q <= total_d;
    end
  end

  assign total_presses_o = total_q;
`endif

  machine_press_solver_chk #(
    .MAX_NUM_LIGHTS  (MAX_NUM_LIGHTS),
    .MAX_NUM_BUTTONS (MAX_NUM_BUTTONS)
  ) u_chk (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .in_valid_i    (in_valid_i),
    .in_ready_i    (in_ready_q),
    .num_lights_i  (in_num_lights_i),
    .num_buttons_i (in_num_buttons_i)
  );

endmodule

// File: tb/tb_machine_press_solver.sv
// Directed self-checking bench for machine_press_solver (default parameters).
module tb_machine_press_solver;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        in_num_lights = 4'd1;
  logic [3:0]        in_num_buttons = 4'd0;
  logic [9:0]        in_target = 10'd0;
  logic [12:0][9:0]  in_buttons = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_found;
  logic [3:0]        out_presses;
  logic [12:0]       out_mask;
`ifdef CFG_SOLVER_TOTAL_EN
  logic [31:0]       total_presses;
`endif

  int total_n = 0;
  int bad_n   = 0;

  logic [12:0][9:0]  ex1_b, ex2_b, ex3_b, big_b, none_b;

  machine_press_solver dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .in_valid_i       (in_valid),
    .in_ready_o       (in_ready),
    .in_num_lights_i  (in_num_lights),
    .in_num_buttons_i (in_num_buttons),
    .in_target_i      (in_target),
    .in_buttons_i     (in_buttons),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .out_found_o      (out_found),
    .out_presses_o    (out_presses),
    .out_mask_o       (out_mask)
`ifdef CFG_SOLVER_TOTAL_EN
    ,
    .total_presses_o  (total_presses)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] nl, input logic [3:0] nb,
                      input logic [9:0] tgt, input logic [12:0][9:0] btn);
    in_num_lights  = nl;
    in_num_buttons = nb;
    in_target      = tgt;
    in_buttons     = btn;
    in_valid       = 1'b1;
    tick();
    in_valid       = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 10000) begin
      tick();
      cyc++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic init_vectors();
    ex1_b = '0;
    ex1_b[0] = 10'b1000; ex1_b[1] = 10'b1010; ex1_b[2] = 10'b0100;
    ex1_b[3] = 10'b1100; ex1_b[4] = 10'b0101; ex1_b[5] = 10'b0011;
    ex2_b = '0;
    ex2_b[0] = 10'b10;
    ex3_b = '0;
    ex3_b[0] = 10'b001; ex3_b[1] = 10'b010; ex3_b[2] = 10'b100;
    big_b = '0;
    big_b[12] = 10'h3FF;
    none_b = '0;
  endtask

  task automatic test_reset();
    do_reset();
    total_n++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad_n++;
      $display("FAIL reset_hs got valid/ready=%b want=01", {out_valid, in_ready});
    end
    total_n++;
    if ({out_found, out_presses, out_mask} !== {1'b0, 4'hF, 13'd0}) begin
      bad_n++;
      $display("FAIL reset_out got=%h want=%h", {out_found, out_presses, out_mask}, {1'b0, 4'hF, 13'd0});
    end
`ifdef CFG_SOLVER_TOTAL_EN
    total_n++;
    if (total_presses !== 32'd0) begin
      bad_n++;
      $display("FAIL reset_total got=%0d want=0", total_presses);
    end
`endif
  endtask

  task automatic test_example();
    int cyc;
    send(4'd4, 4'd6, 10'b0110, ex1_b);
    wait_out(cyc);
    total_n++;
    if (cyc !== 16) begin
      bad_n++;
      $display("FAIL ex1_latency got=%0d want=16", cyc);
    end
    total_n++;
    if ({out_found, out_presses, out_mask} !== {1'b1, 4'd2, 13'b0_0000_0000_1010}) begin
      bad_n++;
      $display("FAIL ex1_result got=%h want=%h", {out_found, out_presses, out_mask}, {1'b1, 4'd2, 13'd10});
    end
    take();
    total_n++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad_n++;
      $display("FAIL ex1_release got valid/ready=%b want=01", {out_valid, in_ready});
    end
  endtask

  task automatic test_unsolvable();
    int cyc;
    send(4'd2, 4'd1, 10'b01, ex2_b);
    wait_out(cyc);
    total_n++;
    if (cyc !== 1) begin
      bad_n++;
      $display("FAIL ex2_latency got=%0d want=1", cyc);
    end
    total_n++;
    if ({out_found, out_presses, out_mask} !== {1'b0, 4'hF, 13'd0}) begin
      bad_n++;
      $display("FAIL ex2_result got=%h want=%h", {out_found, out_presses, out_mask}, {1'b0, 4'hF, 13'd0});
    end
    take();
  endtask

  task automatic test_zero_target();
    int cyc;
    send(4'd3, 4'd3, 10'd0, ex3_b);
    tick();
    total_n++;
    if (out_valid !== 1'b0) begin
      bad_n++;
      $display("FAIL ex3_early_valid got=%b want=0", out_valid);
    end
    wait_out(cyc);
    total_n++;
    if (cyc !== 1) begin
      bad_n++;
      $display("FAIL ex3_latency got=%0d want=1 more cycle", cyc);
    end
    total_n++;
    if ({out_found, out_presses, out_mask} !== {1'b1, 4'd0, 13'd0}) begin
      bad_n++;
      $display("FAIL ex3_result got=%h want=%h", {out_found, out_presses, out_mask}, {1'b1, 4'd0, 13'd0});
    end
    take();
  endtask

  task automatic test_zero_buttons();
    int cyc;
    send(4'd1, 4'd0, 10'b10, none_b);
    wait_out(cyc);
    total_n++;
    if (cyc !== 1) begin
      bad_n++;
      $display("FAIL nb0_latency got=%0d want=1", cyc);
    end
    total_n++;
    if ({out_found, out_presses, out_mask} !== {1'b1, 4'd0, 13'd0}) begin
      bad_n++;
      $display("FAIL nb0_masked got=%h want=%h", {out_found, out_presses, out_mask}, {1'b1, 4'd0, 13'd0});
    end
    take();
    send(4'd2, 4'd0, 10'b10, none_b);
    wait_out(cyc);
    total_n++;
    if ({out_found, out_presses, out_mask} !== {1'b0, 4'hF, 13'd0}) begin
      bad_n++;
      $display("FAIL nb0_unsolved got=%h want=%h", {out_found, out_presses, out_mask}, {1'b0, 4'hF, 13'd0});
    end
    take();
  endtask

  task automatic test_backpressure();
    int cyc;
    send(4'd4, 4'd6, 10'b0110, ex1_b);
    wait_out(cyc);
    for (int i = 0; i < 5; i++) begin
      total_n++;
      if ({out_valid, in_ready, out_found, out_presses, out_mask} !== {1'b1, 1'b0, 1'b1, 4'd2, 13'd10}) begin
        bad_n++;
        $display("FAIL bp_hold%0d got=%h want=%h", i,
                 {out_valid, in_ready, out_found, out_presses, out_mask}, {1'b1, 1'b0, 1'b1, 4'd2, 13'd10});
      end
      tick();
    end
    take();
    total_n++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad_n++;
      $display("FAIL bp_release got valid/ready=%b want=01", {out_valid, in_ready});
    end
  endtask

  task automatic test_big();
    int cyc;
    send(4'd10, 4'd13, 10'h3FF, big_b);
    wait_out(cyc);
    total_n++;
    if (cyc !== 2048) begin
      bad_n++;
      $display("FAIL big_latency got=%0d want=2048", cyc);
    end
    total_n++;
    if ({out_found, out_presses, out_mask} !== {1'b1, 4'd1, 13'h1000}) begin
      bad_n++;
      $display("FAIL big_result got=%h want=%h", {out_found, out_presses, out_mask}, {1'b1, 4'd1, 13'h1000});
    end
    take();
  endtask

`ifdef CFG_SOLVER_TOTAL_EN
  task automatic test_total();
    int cyc;
    logic [31:0] exp_tot [4];
    exp_tot[0] = 32'd2; exp_tot[1] = 32'd2; exp_tot[2] = 32'd2; exp_tot[3] = 32'd4;
    do_reset();
    for (int m = 0; m < 4; m++) begin
      case (m)
        1:       send(4'd2, 4'd1, 10'b01, ex2_b);
        2:       send(4'd3, 4'd3, 10'd0, ex3_b);
        default: send(4'd4, 4'd6, 10'b0110, ex1_b);
      endcase
      wait_out(cyc);
      take();
      total_n++;
      if (total_presses !== exp_tot[m]) begin
        bad_n++;
        $display("FAIL total_m%0d got=%0d want=%0d", m, total_presses, exp_tot[m]);
      end
    end
  endtask
`endif

  task automatic test_reset_mid_search();
    int cyc;
    send(4'd10, 4'd13, 10'h3FF, big_b);
    for (int i = 0; i < 9; i++) tick();
    total_n++;
    if ({out_valid, in_ready} !== 2'b00) begin
      bad_n++;
      $display("FAIL mid_busy got valid/ready=%b want=00", {out_valid, in_ready});
    end
    tick();
    rst = 1'b1;
    tick();
    total_n++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad_n++;
      $display("FAIL mid_reset got valid/ready=%b want=01", {out_valid, in_ready});
    end
`ifdef CFG_SOLVER_TOTAL_EN
    total_n++;
    if (total_presses !== 32'd0) begin
      bad_n++;
      $display("FAIL mid_total got=%0d want=0", total_presses);
    end
`endif
    rst = 1'b0;
    send(4'd4, 4'd6, 10'b0110, ex1_b);
    wait_out(cyc);
    total_n++;
    if ({out_found, out_presses, out_mask} !== {1'b1, 4'd2, 13'd10} || cyc !== 16) begin
      bad_n++;
      $display("FAIL mid_next got=%h lat=%0d want=%h lat=16",
               {out_found, out_presses, out_mask}, cyc, {1'b1, 4'd2, 13'd10});
    end
    take();
  endtask

  initial begin
    init_vectors();
    test_reset();
    test_example();
    test_unsolvable();
    test_zero_target();
    test_zero_buttons();
    test_backpressure();
    test_big();
`ifdef CFG_SOLVER_TOTAL_EN
    test_total();
`endif
    test_reset_mid_search();
    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
